// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for the single-clock FIFO.
// Provides the read-mode enum and the pointer/count width helper.
package sync_fifo_pkg;
  typedef enum logic {RD_STD, RD_FWFT} rd_mode_e;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake/data bundle between a FIFO user (master) and the FIFO (slave).
// Signals: push, din, pop -> FIFO; dout, fifo_empty, fifo_full, almost_full,
// almost_empty, count, overflow, underflow <- FIFO.
// With SYNC_FIFO_STICKY_ERR_EN defined, also err_clr -> FIFO and ovf_sticky, udf_sticky <- FIFO.
interface sync_fifo_if import sync_fifo_pkg::*; #(
  parameter int DWIDTH = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = ptr_w(FIFO_DEPTH);
  logic push;
  logic [DWIDTH-1:0] din;
  logic pop;
  logic [DWIDTH-1:0] dout;
  logic fifo_empty;
  logic fifo_full;
  logic almost_full;
  logic almost_empty;
  logic [CW-1:0] count;
  logic overflow;
  logic underflow;
`ifdef SYNC_FIFO_STICKY_ERR_EN
  logic err_clr;
  logic ovf_sticky;
  logic udf_sticky;
  modport master(output push, din, pop, err_clr,
                 input dout, fifo_empty, fifo_full, almost_full, almost_empty, count,
                       overflow, underflow, ovf_sticky, udf_sticky);
  modport slave(input push, din, pop, err_clr,
                output dout, fifo_empty, fifo_full, almost_full, almost_empty, count,
                       overflow, underflow, ovf_sticky, udf_sticky);
`else
  modport master(output push, din, pop,
                 input dout, fifo_empty, fifo_full, almost_full, almost_empty, count,
                       overflow, underflow);
  modport slave(input push, din, pop,
                output dout, fifo_empty, fifo_full, almost_full, almost_empty, count,
                       overflow, underflow);
`endif
endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DWIDTH x FIFO_DEPTH register array, one sync write port, one async read port.
// Ports: clk; we, waddr, wdata (write); raddr, rdata (read). Contents are never reset.
module sync_fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller with occupancy count, almost flags and
// selectable read mode (RD_STD registered read, RD_FWFT head word shown on dout).
// Ports: clk, rst (async active-high), bus (sync_fifo_if.slave).
// Optional SYNC_FIFO_STICKY_ERR_EN: sticky overflow/underflow flags cleared by err_clr.
module sync_fifo_ctrl import sync_fifo_pkg::*; #(
  parameter int DWIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_THRESH = 6,
  parameter int AEMPTY_THRESH = 1,
  parameter rd_mode_e READ_MODE = RD_STD
) (
  input logic clk,
  input logic rst,
  sync_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_CNT = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_CNT = PW'(AEMPTY_THRESH);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_ctrl: AFULL_THRESH out of range");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ctrl: AEMPTY_THRESH out of range");
  end
  logic [PW-1:0] wr_ptr, rd_ptr, cnt;
  logic empty, full, pop_acc, push_acc;
  logic [DWIDTH-1:0] rdata;
  assign empty = cnt == '0;
  assign full = cnt == FULL_CNT;
  assign pop_acc = bus.pop & ~empty;
  // At full, a push is still taken when a pop frees the head slot at the same edge.
  assign push_acc = bus.push & (~full | pop_acc);
  assign bus.fifo_empty = empty;
  assign bus.fifo_full = full;
  assign bus.almost_full = cnt >= AF_CNT;
  assign bus.almost_empty = cnt <= AE_CNT;
  assign bus.count = cnt;
  assign bus.overflow = bus.push & full & ~pop_acc;
  assign bus.underflow = bus.pop & empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_acc);
      rd_ptr <= rd_ptr + PW'(pop_acc);
      cnt <= cnt + PW'(push_acc) - PW'(pop_acc);
    end
  // Async read of the old word at the write edge gives read-before-write at full without a bypass.
  sync_fifo_mem #(.DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_mem (
    .clk(clk),
    .we(push_acc),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(bus.din),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
  if (READ_MODE == RD_FWFT) begin : g_fwft
    assign bus.dout = empty ? '0 : rdata;
  end else begin : g_std
    logic [DWIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) dout_q <= '0;
      else if (pop_acc) dout_q <= rdata;
    assign bus.dout = dout_q;
  end
`ifdef SYNC_FIFO_STICKY_ERR_EN
  logic ovf_q, udf_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= bus.overflow ? 1'b1 : bus.err_clr ? 1'b0 : ovf_q;
      udf_q <= bus.underflow ? 1'b1 : bus.err_clr ? 1'b0 : udf_q;
    end
  assign bus.ovf_sticky = ovf_q;
  assign bus.udf_sticky = udf_q;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: self-checking bench driving an RD_STD and an RD_FWFT instance in lockstep.
module tb_sync_fifo_ctrl;
  import sync_fifo_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  sync_fifo_if #(.DWIDTH(8), .FIFO_DEPTH(DEPTH)) if_s ();
  sync_fifo_if #(.DWIDTH(8), .FIFO_DEPTH(DEPTH)) if_f ();

  sync_fifo_ctrl #(.DWIDTH(8), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(6), .AEMPTY_THRESH(1),
                   .READ_MODE(RD_STD)) dut_s (.clk(clk), .rst(rst), .bus(if_s.slave));
  sync_fifo_ctrl #(.DWIDTH(8), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(6), .AEMPTY_THRESH(1),
                   .READ_MODE(RD_FWFT)) dut_f (.clk(clk), .rst(rst), .bus(if_f.slave));

  // Reference model: a queue of stored words plus the last word handed out in standard mode.
  logic [7:0] q[$];
  logic [7:0] m_sd;
  logic m_os, m_us;
  logic a_ovf_s, a_ovf_f, a_udf_s, a_udf_f;

  typedef struct {
    logic push, pop;
    logic [7:0] din;
    logic ovf, udf;
    int cnt;
    logic [7:0] sd, fd;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  function automatic vec_t mk(logic pu, logic po, logic [7:0] d, logic o, logic u, int c,
                              logic [7:0] sd, logic [7:0] fd);
    vec_t v;
    v.push = pu; v.pop = po; v.din = d; v.ovf = o; v.udf = u; v.cnt = c; v.sd = sd; v.fd = fd;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_sd = 8'h00;
    m_os = 1'b0;
    m_us = 1'b0;
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    chk("count_std", if_s.count, n);
    chk("count_fwft", if_f.count, n);
    chk("empty_std", if_s.fifo_empty, n == 0);
    chk("empty_fwft", if_f.fifo_empty, n == 0);
    chk("full_std", if_s.fifo_full, n == DEPTH);
    chk("full_fwft", if_f.fifo_full, n == DEPTH);
    chk("afull_std", if_s.almost_full, n >= 6);
    chk("afull_fwft", if_f.almost_full, n >= 6);
    chk("aempty_std", if_s.almost_empty, n <= 1);
    chk("aempty_fwft", if_f.almost_empty, n <= 1);
    chk("dout_std", if_s.dout, m_sd);
    chk("dout_fwft", if_f.dout, n > 0 ? q[0] : 8'h00);
`ifdef SYNC_FIFO_STICKY_ERR_EN
    chk("ovf_sticky", if_s.ovf_sticky, m_os);
    chk("udf_sticky", if_f.udf_sticky, m_us);
`endif
  endtask

  task automatic cyc(input logic pu, input logic po, input logic [7:0] d, input logic ec);
    int sz;
    logic pa, wa, mo, mu;
    @(negedge clk);
    if_s.push = pu; if_s.pop = po; if_s.din = d;
    if_f.push = pu; if_f.pop = po; if_f.din = d;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    if_s.err_clr = ec; if_f.err_clr = ec;
`endif
    #1;
    sz = q.size();
    pa = po && sz > 0;
    wa = pu && (sz < DEPTH || pa);
    mo = pu && sz == DEPTH && !pa;
    mu = po && sz == 0;
    a_ovf_s = if_s.overflow; a_ovf_f = if_f.overflow;
    a_udf_s = if_s.underflow; a_udf_f = if_f.underflow;
    chk("ovf_std", a_ovf_s, mo);
    chk("ovf_fwft", a_ovf_f, mo);
    chk("udf_std", a_udf_s, mu);
    chk("udf_fwft", a_udf_f, mu);
    @(posedge clk);
    if (pa) m_sd = q.pop_front();
    if (wa) q.push_back(d);
    m_os = mo ? 1'b1 : ec ? 1'b0 : m_os;
    m_us = mu ? 1'b1 : ec ? 1'b0 : m_us;
    #1;
    check_state();
    @(negedge clk);
    if_s.push = 0; if_s.pop = 0; if_f.push = 0; if_f.pop = 0;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    if_s.err_clr = 0; if_f.err_clr = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_state();
  endtask

  initial begin
    if_s.push = 0; if_s.pop = 0; if_s.din = 0;
    if_f.push = 0; if_f.pop = 0; if_f.din = 0;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    if_s.err_clr = 0; if_f.err_clr = 0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_empty", if_s.fifo_empty, 1);
    chk("rst_aempty", if_f.almost_empty, 1);
    chk("rst_count", if_s.count, 0);
    chk("rst_dout_std", if_s.dout, 0);
    chk("rst_dout_fwft", if_f.dout, 0);
    repeat (3) cyc(0, 0, 8'h00, 0);

    // Directed table: fill, overflow, push+pop at full, drain across wrap, empty corner cases.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 8'(i + 1), 0, 0, i + 1, 8'h00, 8'h01));
    tbl.push_back(mk(1, 0, 8'h09, 1, 0, 8, 8'h00, 8'h01));
    tbl.push_back(mk(1, 1, 8'h09, 0, 0, 8, 8'h01, 8'h02));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 7 - i, 8'(i + 2), i < 7 ? 8'(i + 3) : 8'h00));
    tbl.push_back(mk(1, 1, 8'hA5, 0, 1, 1, 8'h09, 8'hA5));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h09, 8'hA5));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 8'hA5, 8'h00));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 8'hA5, 8'h00));
    foreach (tbl[i]) begin
      cyc(tbl[i].push, tbl[i].pop, tbl[i].din, 0);
      chk($sformatf("tv%0d_ovf", i), a_ovf_s, tbl[i].ovf);
      chk($sformatf("tv%0d_udf", i), a_udf_f, tbl[i].udf);
      chk($sformatf("tv%0d_cnt", i), if_s.count, tbl[i].cnt);
      chk($sformatf("tv%0d_sd", i), if_s.dout, tbl[i].sd);
      chk($sformatf("tv%0d_fd", i), if_f.dout, tbl[i].fd);
    end

    // Asynchronous reset in the middle of a fill clears state before any clock edge.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h30 + i), 0);
    cyc(0, 1, 8'h00, 0);
    cyc(1, 0, 8'h40, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", if_s.count, 0);
    chk("arst_empty", if_f.fifo_empty, 1);
    chk("arst_dout_std", if_s.dout, 0);
    chk("arst_dout_fwft", if_f.dout, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_state();

    // Steady streaming at count 3.
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h50 + i), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 8'(8'h60 + i), 0);
      chk("stream_count", if_s.count, 3);
      chk("stream_aempty", if_s.almost_empty, 0);
      chk("stream_afull", if_f.almost_full, 0);
    end

    // Randomized traffic with drifting push/pop bias against the model.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) < 100 - bias,
          8'($urandom), $urandom_range(0, 15) == 0);
    end

`ifdef SYNC_FIFO_STICKY_ERR_EN
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(i), 0);
    cyc(1, 0, 8'hEE, 0);
    chk("sticky_set", if_s.ovf_sticky, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 8'h00, 0);
      chk("sticky_hold", if_f.ovf_sticky, 1);
    end
    cyc(0, 0, 8'h00, 1);
    chk("sticky_clr", if_s.ovf_sticky, 0);
    cyc(1, 0, 8'hEF, 1);
    chk("sticky_set_wins", if_s.ovf_sticky, 1);
    do_reset();
    cyc(0, 1, 8'h00, 0);
    chk("udf_sticky_set", if_s.udf_sticky, 1);
    cyc(0, 1, 8'h00, 1);
    chk("udf_sticky_set_wins", if_f.udf_sticky, 1);
    cyc(0, 0, 8'h00, 1);
    chk("udf_sticky_clr", if_s.udf_sticky, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
